// File: rtl/btn_debounce.sv
// Four-button conditioner: 2-flop sync, sampled shift-register debounce, rising-edge pulse.
// Optional U/D auto-repeat is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_debounce #(
  parameter int unsigned CLK_HZ             = 100_000_000,
  parameter int unsigned SAMPLE_HZ          = 1_000,
  parameter int unsigned DB_SAMPLES         = 8,
  parameter int unsigned REPEAT_DELAY_TICKS = 500,
  parameter int unsigned REPEAT_RATE_TICKS  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       btnD,
  output logic       o_btnL,
  output logic       o_btnR,
  output logic       o_btnU,
  output logic       o_btnD,
  output logic [3:0] o_level
);

  localparam int unsigned TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 2) begin : g_bad_div
    $fatal(1, "btn_debounce: CLK_HZ/SAMPLE_HZ must be at least 2");
  end
  if (DB_SAMPLES < 2 || DB_SAMPLES > 16) begin : g_bad_samples
    $fatal(1, "btn_debounce: DB_SAMPLES must be in 2..16");
  end
  if (REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_bad_repeat
    $fatal(1, "btn_debounce: repeat tick counts must be at least 1");
  end

  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt_q <= '0;
    else               tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // Bit order {D,U,R,L} throughout.
  logic [3:0]            raw;
  logic [3:0]            sync1_q, sync2_q;
  logic [3:0]            level_q, level_dly_q;
  logic [3:0]            rise;
  logic [3:0]            pulse_q;
  logic [DB_SAMPLES-1:0] shift_q [4];

  assign raw  = {btnD, btnU, btnR, btnL};
  assign rise = level_q & ~level_dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      pulse_q     <= '0;
      for (int i = 0; i < 4; i++) shift_q[i] <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      level_dly_q <= level_q;
      pulse_q     <= rise;
      for (int i = 0; i < 4; i++) begin
        if (tick) shift_q[i] <= {shift_q[i][DB_SAMPLES-2:0], sync2_q[i]};
        if (&shift_q[i])       level_q[i] <= 1'b1;
        else if (~|shift_q[i]) level_q[i] <= 1'b0;
      end
    end
  end

  assign o_btnL  = pulse_q[0];
  assign o_btnR  = pulse_q[1];
  assign o_level = level_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                                    REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int unsigned CW      = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {StIdle, StHold, StRpt} rpt_st_e;

  rpt_st_e       st_q   [2];
  logic [CW-1:0] rcnt_q [2];
  logic [1:0]    rpt_q;

  // Index 0 serves U (level bit 2), index 1 serves D (level bit 3).
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= StIdle;
        rcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rpt_q[i] <= 1'b0;
        if (!level_q[i+2]) begin
          st_q[i]   <= StIdle;
          rcnt_q[i] <= '0;
        end else begin
          unique case (st_q[i])
            StIdle: begin
              st_q[i]   <= StHold;
              rcnt_q[i] <= '0;
            end
            StHold: if (tick) begin
              if (rcnt_q[i] == CW'(REPEAT_DELAY_TICKS - 1)) begin
                rpt_q[i]  <= 1'b1;
                st_q[i]   <= StRpt;
                rcnt_q[i] <= '0;
              end else if (rcnt_q[i] != '1) begin
                rcnt_q[i] <= rcnt_q[i] + 1'b1;
              end
            end
            StRpt: if (tick) begin
              if (rcnt_q[i] == CW'(REPEAT_RATE_TICKS - 1)) begin
                rpt_q[i]  <= 1'b1;
                rcnt_q[i] <= '0;
              end else if (rcnt_q[i] != '1) begin
                rcnt_q[i] <= rcnt_q[i] + 1'b1;
              end
            end
            default: st_q[i] <= StIdle;
          endcase
        end
      end
    end
  end

  assign o_btnU = pulse_q[2] | rpt_q[0];
  assign o_btnD = pulse_q[3] | rpt_q[1];
`else
  assign o_btnU = pulse_q[2];
  assign o_btnD = pulse_q[3];
`endif

endmodule
